// File: rtl/ars_mod_inv.sv
// GF(2^M) multiplicative inverter, polynomial basis, f(x) = x^M + POLY.
// Binary extended Euclid: one reduction step per clock with a start/busy/done handshake.
module ars_mod_inv #(
    parameter int M = 233,
    parameter logic [M-1:0] POLY = {{(M-75){1'b0}}, 1'b1, {73{1'b0}}, 1'b1}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] din,
    output logic [M-1:0] dout,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int DW = $clog2(M + 1);
    localparam logic [M-1:0] ONE_M = {{(M-1){1'b0}}, 1'b1};
    localparam logic [M:0]   ONE_V = {{M{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t         state, state_nx;
    logic [M-1:0]   u, g1, g2, res;
    logic [M:0]     v;
    logic           err_pend;
    logic [DW-1:0]  deg_u, deg_v;

    function automatic logic [DW-1:0] deg_of(input logic [M:0] x);
        deg_of = '0;
        for (int i = 0; i <= M; i++) begin
            if (x[i]) deg_of = DW'(i);
        end
    endfunction

    // g * x^-1 mod f: an odd g first absorbs f, whose x^M term lands in the top bit after the shift
    function automatic logic [M-1:0] halve(input logic [M-1:0] g);
        if (g[0]) halve = {1'b1, g[M-1:1] ^ POLY[M-1:1]};
        else      halve = {1'b0, g[M-1:1]};
    endfunction

    assign deg_u = deg_of({1'b0, u});
    assign deg_v = deg_of(v);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = (din == '0) ? FIN : RUN;
            RUN: begin
                busy = 1'b1;
                if (u == ONE_M || v == ONE_V) state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Invariants while running: g1*a == u and g2*a == v (mod f)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u        <= '0;
            v        <= '0;
            g1       <= '0;
            g2       <= '0;
            res      <= '0;
            err_pend <= 1'b0;
            dout     <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (din == '0) begin
                            res      <= '0;
                            err_pend <= 1'b1;
                        end else begin
                            u        <= din;
                            v        <= {1'b1, POLY};
                            g1       <= ONE_M;
                            g2       <= '0;
                            err_pend <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (u == ONE_M) begin
                        res <= g1;
                    end else if (v == ONE_V) begin
                        res <= g2;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        g1 <= halve(g1);
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        g2 <= halve(g2);
                    end else if (deg_u > deg_v) begin
                        u  <= u ^ v[M-1:0];
                        g1 <= g1 ^ g2;
                    end else begin
                        v  <= v ^ {1'b0, u};
                        g2 <= g2 ^ g1;
                    end
                end
                FIN: begin
                    dout <= res;
                    err  <= err_pend;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ars_mod_inv.sv
// Bench for ars_mod_inv: directed and random operands, checked against a GF(2^233) multiply model.
module tb_ars_mod_inv;

    localparam int M = 233;
    localparam logic [M-1:0] POLY  = {{(M-75){1'b0}}, 1'b1, {73{1'b0}}, 1'b1};
    localparam logic [M-1:0] ONE_M = {{(M-1){1'b0}}, 1'b1};
    localparam int LAT_MAX = 4 * M + 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [M-1:0] din;
    logic [M-1:0] dout;
    logic         busy;
    logic         done;
    logic         err;

    typedef struct {
        logic [M-1:0] din;
        logic         err;
        int           lo;
        int           hi;
        longint       acc;
    } op_t;

    op_t          q[$];
    int           checks   = 0;
    int           failures = 0;
    longint       cyc      = 0;
    logic [M-1:0] last_dout = '0;
    logic         last_err  = 1'b0;
    logic         prev_done = 1'b0;

    ars_mod_inv #(.M(M), .POLY(POLY)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din),
        .dout(dout), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Carry-less product reduced by x^233 = x^74 + 1
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic         c;
        r = '0;
        for (int i = M - 1; i >= 0; i--) begin
            c = r[M-1];
            r = r << 1;
            if (c) r = r ^ POLY;
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input bit ok, input logic [M-1:0] act, input logic [M-1:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Every cycle out of reset: DONE must line up with a queued operation, otherwise outputs hold
    always @(negedge clk) begin
        op_t    e;
        longint lat;
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                chk("done_expected", q.size() != 0, M'(q.size()), ONE_M);
                if (q.size() != 0) begin
                    e   = q.pop_front();
                    lat = cyc - e.acc;
                    chk("err_flag", err == e.err, M'(err), M'(e.err));
                    if (e.err) chk("dout_on_err", dout == '0, dout, '0);
                    else       chk("inverse", gf_mul(e.din, dout) == ONE_M, gf_mul(e.din, dout), ONE_M);
                    chk("latency", lat >= e.lo && lat <= e.hi, M'(lat), M'(e.hi));
                end
                chk("busy_in_done", !busy, M'(busy), '0);
                chk("done_width", !prev_done, M'(prev_done), '0);
                last_dout = dout;
                last_err  = err;
            end else begin
                chk("dout_hold", dout == last_dout, dout, last_dout);
                chk("err_hold", err == last_err, M'(err), M'(last_err));
            end
            prev_done = done;
        end
    end

    // Called on a falling edge; returns one falling edge after the accepting rising edge
    task automatic launch(input logic [M-1:0] a, input int lo, input int hi);
        op_t e;
        start = 1'b1;
        din   = a;
        e.din = a;
        e.err = (a == '0);
        e.lo  = lo;
        e.hi  = hi;
        e.acc = cyc;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        din   = ~a;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < LAT_MAX + 8 && !seen; n++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        chk("done_timeout", seen, M'(seen), ONE_M);
    endtask

    task automatic run(input logic [M-1:0] a, input int lo, input int hi);
        launch(a, lo, hi);
        wait_done();
    endtask

    function automatic logic [M-1:0] rand_op();
        logic [255:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return (w[M-1:0] == '0) ? ONE_M : w[M-1:0];
    endfunction

    initial begin
        logic [M-1:0] inv_x;
        logic [M-1:0] big;
        inv_x = '0;
        inv_x[232] = 1'b1;
        inv_x[73]  = 1'b1;
        big   = '1;

        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;
        repeat (3) @(negedge clk);
        chk("reset_dout", dout == '0, dout, '0);
        chk("reset_busy", busy == 1'b0, M'(busy), '0);
        chk("reset_done", done == 1'b0, M'(done), '0);
        chk("reset_err", err == 1'b0, M'(err), '0);
        rst_n = 1'b1;
        @(negedge clk);

        chk("model_pin_x", gf_mul(M'(2), inv_x) == ONE_M, gf_mul(M'(2), inv_x), ONE_M);
        chk("model_pin_one", gf_mul(ONE_M, big) == big, gf_mul(ONE_M, big), big);

        run(ONE_M, 1, 3);
        chk("inv_of_1", dout == ONE_M, dout, ONE_M);
        run(M'(2), 2, LAT_MAX);
        chk("inv_of_x", dout == inv_x, dout, inv_x);
        run('0, 2, 2);
        chk("zero_err", err == 1'b1, M'(err), ONE_M);
        chk("zero_dout", dout == '0, dout, '0);
        run(M'(3), 2, LAT_MAX);
        chk("err_cleared", err == 1'b0, M'(err), '0);
        run(inv_x, 2, LAT_MAX);
        chk("inv_of_inv_x", dout == M'(2), dout, M'(2));
        run(big, 2, LAT_MAX);
        run(POLY, 2, LAT_MAX);

        // START during RUN with a different operand must be ignored
        launch(big, 2, LAT_MAX);
        repeat (4) @(negedge clk);
        chk("busy_in_run", busy == 1'b1, M'(busy), ONE_M);
        start = 1'b1;
        din   = M'(2);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("ignored_start", gf_mul(big, dout) == ONE_M, gf_mul(big, dout), ONE_M);

        // Reset mid-operation aborts with no DONE
        launch(big, 2, LAT_MAX);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_dout", dout == '0, dout, '0);
        chk("abort_busy", busy == 1'b0, M'(busy), '0);
        chk("abort_done", done == 1'b0, M'(done), '0);
        chk("abort_err", err == 1'b0, M'(err), '0);
        q.delete();
        last_dout = '0;
        last_err  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run(M'(2), 2, LAT_MAX);
        chk("after_reset", dout == inv_x, dout, inv_x);

        for (int k = 0; k < 40; k++) run(rand_op(), 2, LAT_MAX);

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size() == 0, M'(q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
